toggle_event_rx: RTL and testbench
==================================

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (legal 2..4).
REQ-002 SHALL have parameter PEND_W, default 3, pending-counter width; max queued events = 2^PEND_W-1.
REQ-003 SHALL have parameter CNT_W, default 16, accepted-event counter width.
REQ-004 SHALL have parameter GLITCH_CYC, default 4, deglitch stability length in cycles (used only with TOGGLE_RX_DEGLITCH_EN).
REQ-005 SHALL have port qzt, input, 1, sole clock; all state on posedge qzt.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port tog_in, input, 1, asynchronous toggle-encoded event line; each level change = one event.
REQ-008 SHALL have port evt_ack, input, 1, consumer acknowledge; pops one event when evt_valid=1.
REQ-009 SHALL have port clr_ovf, input, 1, clears the overflow flag.
REQ-010 SHALL have port evt_valid, output, 1, high while at least one event is pending.
REQ-011 SHALL have port pending, output, PEND_W, number of queued unacknowledged events.
REQ-012 SHALL have port evt_count, output, CNT_W, count of accepted events, wraps modulo 2^CNT_W.
REQ-013 SHALL have port overflow, output, 1, sticky flag: an event was dropped.

Function
REQ-014 SHALL pass tog_in through a SYNC_STAGES-deep flip-flop chain before any use; tog_in SHALL NOT drive other logic.
REQ-015 SHALL keep a reference level tog_ref; transition detected when synchronized value != tog_ref, then tog_ref updated to the synchronized value in the same cycle.
REQ-016 SHALL be in PRIME state for SYNC_STAGES+1 cycles after reset release: tog_ref tracks the synchronized value, no events generated (initial line level is never an event).
REQ-017 SHALL then enter RUN state and remain there until reset.
REQ-018 SHALL, without deglitch, assert evt_valid exactly SYNC_STAGES+1 rising edges after the first edge sampling a new tog_in level, given pending was 0.
REQ-019 SHALL on detected transition with pending < max: pending+1, evt_count+1.
REQ-020 SHALL on detected transition with pending = max: drop event, pending and evt_count unchanged, overflow set.
REQ-021 SHALL on evt_ack with evt_valid=1 and no transition: pending-1.
REQ-022 SHALL on simultaneous transition and valid ack: pending unchanged, evt_count+1, overflow unaffected even if pending = max.
REQ-023 SHALL ignore evt_ack when evt_valid=0 (no underflow).
REQ-024 SHALL drive evt_valid = (pending != 0) from registered state only, no combinational path from evt_ack or tog_in.
REQ-025 SHALL clear overflow on clr_ovf; a set condition in the same cycle wins (overflow stays 1).
REQ-026 SHALL wrap evt_count from 2^CNT_W-1 to 0 without side effect.

Reset
REQ-027 SHALL on rst_n=0 immediately force: sync chain 0, tog_ref 0, state PRIME, pending 0, evt_valid 0, evt_count 0, overflow 0, deglitch counter 0.
REQ-028 SHALL on reset mid-operation discard all pending events and re-prime; no event generated from line level at release.

Configuration
REQ-029 SHALL, with macro TOGGLE_RX_DEGLITCH_EN defined, accept a transition only after the synchronized value differs from tog_ref for GLITCH_CYC consecutive cycles; shorter excursions are ignored and the stability counter restarts; added latency = GLITCH_CYC-1 cycles.
REQ-030 SHALL, without TOGGLE_RX_DEGLITCH_EN, contain no deglitch counter and accept every synchronized level change as per REQ-018.

Verification
REQ-031 SHALL cover: reset release with tog_in=1 held -> no evt_valid, pending=0 for 20 cycles.
REQ-032 SHALL cover: after priming, tog_in 0->1 once -> evt_valid high at edge 3 (SYNC_STAGES=2), pending=1, evt_count=1; evt_ack one cycle -> pending=0, evt_valid=0 next cycle.
REQ-033 SHALL cover: 9 toggles spaced 5 cycles, no ack, PEND_W=3 -> pending=7, evt_count=7, overflow=1; clr_ovf -> overflow=0.
REQ-034 SHALL cover: pending=7, transition detected in same cycle as evt_ack -> pending stays 7, evt_count+1, overflow stays 0.
REQ-035 SHALL cover: with TOGGLE_RX_DEGLITCH_EN, GLITCH_CYC=4, 2-cycle pulse on tog_in -> no event; 10-cycle level change -> exactly one event.
REQ-036 SHALL cover: evt_count preloaded near wrap via 2^CNT_W events (CNT_W=4 build) -> 16th accepted event gives evt_count=0.

Source files
------------

// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - toggle-encoded event receiver with pending queue; optional deglitch via TOGGLE_RX_DEGLITCH_EN
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 16,
  parameter int GLITCH_CYC  = 4
) (
  input  logic              qzt,
  input  logic              rst_n,
  input  logic              tog_in,
  input  logic              evt_ack,
  input  logic              clr_ovf,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam int                PRIME_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || GLITCH_CYC < 1 || PEND_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("toggle_event_rx: illegal parameter set");
  end

  state_t                 state;
  logic [PRIME_W-1:0]     prime_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_val;
  logic                   tog_ref;
  logic                   differ;
  logic                   trans;
  logic                   ack_ok;
  logic                   pend_full;

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_val != tog_ref);

  // Synchronizer chain: the only consumer of the raw asynchronous line
  always_ff @(posedge qzt or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
    end
  end

`ifdef TOGGLE_RX_DEGLITCH_EN
  localparam int                 GLITCH_W    = $clog2(GLITCH_CYC) + 1;
  localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYC - 1);

  logic [GLITCH_W-1:0] glitch_cnt;

  // A level change is accepted on its GLITCH_CYC-th consecutive differing cycle
  assign trans = (state == ST_RUN) && differ && (glitch_cnt == GLITCH_LAST);

  // Stability counter restarts whenever the line returns to the reference level
  always_ff @(posedge qzt or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (state != ST_RUN || !differ || trans) begin
      glitch_cnt <= '0;
    end else begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`else
  assign trans = (state == ST_RUN) && differ;
`endif

  // Prime/run sequencing; reference level follows the line while priming
  always_ff @(posedge qzt or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
      tog_ref   <= 1'b0;
    end else begin
      case (state)
        ST_PRIME: begin
          tog_ref <= sync_val;
          if (prime_cnt == PRIME_LAST) begin
            state <= ST_RUN;
          end else begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
          end
        end
        default: begin
          if (trans) begin
            tog_ref <= sync_val;
          end
        end
      endcase
    end
  end

  assign ack_ok    = evt_ack && (pending != '0);
  assign pend_full = (pending == PEND_MAX);

  // Pending queue depth, accepted-event counter and sticky drop flag
  always_ff @(posedge qzt or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (trans && (ack_ok || !pend_full)) begin
        evt_count <= evt_count + CNT_W'(1);
      end
      if (trans && !ack_ok && !pend_full) begin
        pending <= pending + PEND_W'(1);
      end else if (!trans && ack_ok) begin
        pending <= pending - PEND_W'(1);
      end
      overflow <= (trans && !ack_ok && pend_full) || (overflow && !clr_ovf);
    end
  end

  assign evt_valid = (pending != '0);

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - self-checking bench for toggle_event_rx against a queue-count reference model
module tb_toggle_event_rx;

  localparam int SS   = 2;
  localparam int PW   = 3;
  localparam int CW   = 4;
  localparam int GC   = 4;
`ifdef TOGGLE_RX_DEGLITCH_EN
  localparam int DG   = 1;
`else
  localparam int DG   = 0;
`endif
  localparam int LAT  = SS + 1 + ((DG != 0) ? (GC - 1) : 0);
  localparam int PMAX = (1 << PW) - 1;

  logic          qzt;
  logic          rst_n;
  logic          tog_in;
  logic          evt_ack;
  logic          clr_ovf;
  logic          evt_valid;
  logic [PW-1:0] pending;
  logic [CW-1:0] evt_count;
  logic          overflow;

  toggle_event_rx #(
    .SYNC_STAGES(SS),
    .PEND_W     (PW),
    .CNT_W      (CW),
    .GLITCH_CYC (GC)
  ) dut (
    .qzt      (qzt),
    .rst_n    (rst_n),
    .tog_in   (tog_in),
    .evt_ack  (evt_ack),
    .clr_ovf  (clr_ovf),
    .evt_valid(evt_valid),
    .pending  (pending),
    .evt_count(evt_count),
    .overflow (overflow)
  );

  initial qzt = 1'b0;
  always #5 qzt = ~qzt;

  int total = 0;
  int bad   = 0;

  // reference model: line history, reference level, queue depth, counter, flag
  bit line_hist[$];
  int m_pend;
  int m_cnt;
  bit m_ovf;
  bit m_ref;
  int m_prime;
  int m_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    line_hist.delete();
    m_pend  = 0;
    m_cnt   = 0;
    m_ovf   = 0;
    m_ref   = 0;
    m_prime = 0;
    m_run   = 0;
  endtask

  // One clock edge of the spec's behaviour: the detector sees the line level
  // that was sampled SS edges earlier (zero before the chain has filled).
  task automatic model_edge();
    bit vis;
    bit trans;
    bit ack_ok;
    bit new_ovf;
    line_hist.push_back(tog_in);
    if (line_hist.size() > 16) void'(line_hist.pop_front());
    vis    = (line_hist.size() > SS) ? line_hist[line_hist.size() - 1 - SS] : 1'b0;
    trans  = 0;
    ack_ok = evt_ack && (m_pend > 0);
    if (m_prime < SS + 1) begin
      m_ref = vis;
      m_prime++;
    end else if (DG != 0) begin
      m_run = (vis != m_ref) ? m_run + 1 : 0;
      if (m_run >= GC) begin
        trans = 1;
        m_ref = vis;
        m_run = 0;
      end
    end else if (vis != m_ref) begin
      trans = 1;
      m_ref = vis;
    end
    new_ovf = m_ovf && !clr_ovf;
    if (trans) begin
      if (ack_ok) m_cnt = (m_cnt + 1) % (1 << CW);
      else if (m_pend == PMAX) new_ovf = 1;
      else begin
        m_pend++;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end else if (ack_ok) begin
      m_pend--;
    end
    m_ovf = new_ovf;
  endtask

  task automatic step();
    @(posedge qzt);
    model_edge();
    #1;
    chk("pending",   32'(pending),   32'(m_pend));
    chk("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
    chk("evt_count", 32'(evt_count), 32'(m_cnt));
    chk("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic do_reset(input bit lvl);
    rst_n   = 1'b0;
    tog_in  = lvl;
    evt_ack = 1'b0;
    clr_ovf = 1'b0;
    #1;
    model_reset();
    chk("rst_pending",   32'(pending),   32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_count", 32'(evt_count), 32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    repeat (3) @(posedge qzt);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    tog_in  = 1'b0;
    evt_ack = 1'b0;
    clr_ovf = 1'b0;
    #1;

    // release with line held high: priming must swallow the initial level
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      evt_ack = ($urandom_range(0, 1) == 1);
      step();
    end
    evt_ack = 1'b0;
    chk("prime_valid",   32'(evt_valid), 32'd0);
    chk("prime_pending", 32'(pending),   32'd0);

    // single 0->1 toggle: latency, then one-cycle ack drains it
    do_reset(1'b0);
    repeat (SS + 4) step();
    tog_in = 1'b1;
    repeat (LAT - 1) step();
    chk("lat_early", 32'(evt_valid), 32'd0);
    step();
    chk("lat_valid",   32'(evt_valid), 32'd1);
    chk("lat_pending", 32'(pending),   32'd1);
    chk("lat_count",   32'(evt_count), 32'd1);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    chk("ack_pending", 32'(pending),   32'd0);
    chk("ack_valid",   32'(evt_valid), 32'd0);

    // nine toggles without ack overflow a depth-7 queue
    do_reset(1'b0);
    repeat (SS + 4) step();
    for (int i = 0; i < 9; i++) begin
      tog_in = ~tog_in;
      repeat (5) step();
    end
    repeat (LAT) step();
    chk("ovf_pending", 32'(pending),   32'd7);
    chk("ovf_count",   32'(evt_count), 32'd7);
    chk("ovf_flag",    32'(overflow),  32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // full queue: transition lands on the same edge as an ack
    tog_in = ~tog_in;
    repeat (LAT - 1) step();
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    chk("full_ack_pending", 32'(pending),   32'd7);
    chk("full_ack_count",   32'(evt_count), 32'd8);
    chk("full_ack_ovf",     32'(overflow),  32'd0);

    // counter wrap: 16 accepted events in a 4-bit counter
    do_reset(1'b0);
    repeat (SS + 4) step();
    for (int i = 1; i <= 16; i++) begin
      tog_in = ~tog_in;
      repeat (LAT) step();
      evt_ack = 1'b1;
      step();
      evt_ack = 1'b0;
      if (i == 15) chk("wrap_count15", 32'(evt_count), 32'd15);
      if (i == 16) chk("wrap_count0",  32'(evt_count), 32'd0);
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);

`ifdef TOGGLE_RX_DEGLITCH_EN
    // short pulse is rejected, a long level change is accepted once
    do_reset(1'b0);
    repeat (SS + 4) step();
    tog_in = 1'b1;
    repeat (2) step();
    tog_in = 1'b0;
    repeat (12) step();
    chk("glitch_pending", 32'(pending),   32'd0);
    chk("glitch_count",   32'(evt_count), 32'd0);
    tog_in = 1'b1;
    repeat (15) step();
    chk("stable_pending", 32'(pending),   32'd1);
    chk("stable_count",   32'(evt_count), 32'd1);
`endif

    // randomized traffic with occasional mid-operation resets
    do_reset($urandom_range(0, 1) == 1);
    for (int i = 1; i <= 3000; i++) begin
      if (i % 500 == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 3) == 0) tog_in = ~tog_in;
      evt_ack = ($urandom_range(0, 2) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
